// File: rtl/i2c_host_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// i2c_host_pkg
//   Shared definitions for the I2C core processor-port bus initiator:
//   register address map, initiator FSM state encoding and the address
//   legality check applied to every incoming command.
// ---------------------------------------------------------------------------
package i2c_host_pkg;

  // I2C core processor-port register map
  localparam logic [7:0] REG_RR   = 8'h00;  // receive register, read-only
  localparam logic [7:0] REG_PRER = 8'h02;  // clock prescaler
  localparam logic [7:0] REG_CTR  = 8'h04;  // control
  localparam logic [7:0] REG_SR   = 8'h08;  // status, read-only
  localparam logic [7:0] REG_TO   = 8'h0A;  // timeout
  localparam logic [7:0] REG_ADDR = 8'h0C;  // own slave address
  localparam logic [7:0] REG_DR   = 8'h0E;  // transmit data

  // Initiator FSM states (one strobe cycle = ADDR -> DATA -> HOLD -> RECOV)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RECOV = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Address is legal if it is mapped; RR and SR only accept reads (rw=0).
  function automatic logic addr_legal(input logic [7:0] addr, input logic rw);
    logic ok;
    case (addr)
      REG_RR, REG_SR:                               ok = ~rw;
      REG_PRER, REG_CTR, REG_TO, REG_ADDR, REG_DR:  ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/i2c_host_bus_master_bus_phase_timer.sv
// ---------------------------------------------------------------------------
// bus_phase_timer
//   Loadable down-counter timing each bus phase. Loaded with (cycles-1) on
//   phase entry, counts down to zero and stays there (no wrap).
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count
//   done       : count is zero (last cycle of the current phase)
// ---------------------------------------------------------------------------
module bus_phase_timer
  import i2c_host_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;

  // Phase counter: load on phase entry, otherwise decrement and saturate at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value = cnt_r;
  assign done  = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/i2c_host_bus_master.sv
// ---------------------------------------------------------------------------
// i2c_host_bus_master
//   Bus initiator for the I2C core processor register port. Each accepted
//   single-register command becomes one timed as/ds strobe cycle:
//     ADDR  (as=1, ds=0) SETUP_CYC cycles
//     DATA  (as=1, ds=1) STROBE_CYC cycles, read data sampled on the last one
//     HOLD  (as=1, ds=0) HOLD_CYC cycles
//     RECOV (as=0, ds=0) RECOV_CYC cycles, rsp_valid on the first one
//   Illegal commands never touch the bus and respond with rsp_err the cycle
//   after acceptance.
// Ports
//   clk, rst                        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_rw/cmd_addr/cmd_wdata       : command (rw=1 write, 0 read)
//   rsp_valid/rsp_rdata/rsp_err     : completion pulse, last read data, error
//   bus_addr/bus_wdata/bus_as/
//   bus_ds/bus_rw                   : to core add_bus/data_in/as/ds/rw
//   bus_rdata                       : from core data_out
//   irq/irq_sync                    : core interrupt and its synchronised copy
// ---------------------------------------------------------------------------
module i2c_host_bus_master
  import i2c_host_pkg::*;
#(
  parameter int SETUP_CYC  = 3,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_as,
  output logic       bus_ds,
  output logic       bus_rw,
  input  logic [7:0] bus_rdata,
  input  logic       irq,
  output logic       irq_sync
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic             legal_s;
  logic             capture_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_ld_val_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_done_s;

  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [7:0]       rsp_rdata_r;
  logic [7:0]       bus_addr_r;
  logic [7:0]       bus_wdata_r;
  logic             bus_rw_r;
  logic             bus_as_r;
  logic             bus_ds_r;
  logic             irq_meta_r;
  logic             irq_sync_r;

  // cmd_ready is a register that is only ever high in IDLE
  assign accept_s  = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
  assign legal_s   = addr_legal(cmd_addr, cmd_rw);
  // Last strobe cycle of a read: counter has reached zero inside DATA
  assign capture_s = (state_r == ST_DATA) && (tmr_val_s == CNT_ZERO) && !bus_rw_r;

  bus_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_ld_val_s),
    .value    (tmr_val_s),
    .done     (tmr_done_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and phase-timer load on every phase entry
  always_comb begin
    state_nxt_s  = state_r;
    tmr_load_s   = 1'b0;
    tmr_ld_val_s = CNT_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && legal_s) begin
          state_nxt_s  = ST_ADDR;
          tmr_load_s   = 1'b1;
          tmr_ld_val_s = SETUP_LD;
        end else if (accept_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (tmr_done_s) begin
          state_nxt_s  = ST_DATA;
          tmr_load_s   = 1'b1;
          tmr_ld_val_s = STROBE_LD;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (tmr_done_s) begin
          state_nxt_s  = ST_HOLD;
          tmr_load_s   = 1'b1;
          tmr_ld_val_s = HOLD_LD;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_HOLD: begin
        if (tmr_done_s) begin
          state_nxt_s  = ST_RECOV;
          tmr_load_s   = 1'b1;
          tmr_ld_val_s = RECOV_LD;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_RECOV: begin
        if (tmr_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECOV;
        end
      end
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered handshake/strobes, decoded from the state being entered so
  // they line up with state_r; cmd_ready re-arms one cycle after IDLE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r <= 1'b0;
      bus_as_r    <= 1'b0;
      bus_ds_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      cmd_ready_r <= (state_r == ST_IDLE) && !accept_s;
      bus_as_r    <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA) ||
                     (state_nxt_s == ST_HOLD);
      bus_ds_r    <= (state_nxt_s == ST_DATA);
      rsp_valid_r <= ((state_r == ST_HOLD) && (state_nxt_s == ST_RECOV)) ||
                     (state_nxt_s == ST_ERR);
      rsp_err_r   <= (state_nxt_s == ST_ERR);
    end
  end

  // Bus command registers: loaded only by a legal accept, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr_r  <= 8'h00;
      bus_wdata_r <= 8'h00;
      bus_rw_r    <= 1'b0;
    end else if (accept_s && legal_s) begin
      bus_addr_r  <= cmd_addr;
      bus_wdata_r <= cmd_wdata;
      bus_rw_r    <= cmd_rw;
    end else begin
      bus_addr_r  <= bus_addr_r;
      bus_wdata_r <= bus_wdata_r;
      bus_rw_r    <= bus_rw_r;
    end
  end

  // Read data capture on the last strobe cycle; held across writes and errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_r <= 8'h00;
    end else if (capture_s) begin
      rsp_rdata_r <= bus_rdata;
    end else begin
      rsp_rdata_r <= rsp_rdata_r;
    end
  end

  // Two-flop synchroniser for the core interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta_r <= 1'b0;
      irq_sync_r <= 1'b0;
    end else begin
      irq_meta_r <= irq;
      irq_sync_r <= irq_meta_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_rw    = bus_rw_r;
  assign bus_as    = bus_as_r;
  assign bus_ds    = bus_ds_r;
  assign irq_sync  = irq_sync_r;

endmodule

// File: tb/tb_i2c_host_bus_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_host_bus_master
//   Drives register commands into i2c_host_bus_master, with a small model of
//   the I2C core processor register port on the bus side. Expected responses
//   are queued when a command is accepted and compared against responses
//   collected by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_i2c_host_bus_master;

  localparam int SETUP_CYC  = 3;
  localparam int STROBE_CYC = 4;
  localparam int HOLD_CYC   = 1;
  localparam int RECOV_CYC  = 2;
  localparam int LAT_OK     = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC;  // 9
  localparam int LAT_ERR    = 1;
  localparam int PERIOD     = LAT_OK + RECOV_CYC + 1;                 // 12
  localparam int AS_LEN     = SETUP_CYC + STROBE_CYC + HOLD_CYC;      // 8

  typedef struct { logic err; logic [7:0] rdata; int acc; int lat; } exp_t;
  typedef struct { logic err; logic [7:0] rdata; int cyc; } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_as, bus_ds, bus_rw;
  logic       irq, irq_sync;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] last_rd = 8'h00;

  exp_t exp_q[$];
  obs_t rsp_q[$];
  int   as_q[$], ds_q[$], gap_q[$];
  int   as_len = 0, ds_len = 0, low_len = 0, as_total = 0, ds_total = 0;
  obs_t mon_o;

  i2c_host_bus_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_as(bus_as),
    .bus_ds(bus_ds), .bus_rw(bus_rw), .bus_rdata(bus_rdata),
    .irq(irq), .irq_sync(irq_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core register-port model: RR/SR return fixed values, others are storage
  logic [7:0] core_mem [0:15];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) core_mem[i] <= 8'h00;
    end else if (bus_as && bus_ds && bus_rw) begin
      core_mem[bus_addr[3:0]] <= bus_wdata;
    end
  end
  always_comb begin
    case (bus_addr)
      8'h00:   bus_rdata = 8'h3C;
      8'h08:   bus_rdata = 8'h81;
      default: bus_rdata = core_mem[bus_addr[3:0]];
    endcase
  end

  // Monitor: responses and strobe run lengths, sampled on the falling edge
  always @(negedge clk) begin
    if (rsp_valid) begin
      mon_o.err = rsp_err; mon_o.rdata = rsp_rdata; mon_o.cyc = cyc;
      rsp_q.push_back(mon_o);
    end
    if (bus_as) begin
      if (low_len > 0) gap_q.push_back(low_len);
      low_len = 0; as_len++; as_total++;
    end else begin
      if (as_len > 0) as_q.push_back(as_len);
      as_len = 0; low_len++;
    end
    if (bus_ds) begin
      ds_len++; ds_total++;
    end else begin
      if (ds_len > 0) ds_q.push_back(ds_len);
      ds_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic exp_t mk(input logic err, input logic [7:0] rd, input int acc, input int lat);
    exp_t e;
    e.err = err; e.rdata = rd; e.acc = acc; e.lat = lat;
    return e;
  endfunction

  // Drive one command and return the cycle stamp of the accepting cycle.
  task automatic issue(input logic rw, input logic [7:0] addr, input logic [7:0] wd, output int acc);
    acc = -1;
    cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (acc < 0) begin errors++; $display("FAIL accept_timeout: addr %h not accepted in 40 cycles", addr); end
  endtask

  // Wait (bounded) until every expected response has been observed.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = (rsp_q.size() >= exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00; irq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset cmd_ready: got %b required 0", cmd_ready); end
    checks++; if (bus_as !== 1'b0 || bus_ds !== 1'b0) begin errors++; $display("FAIL reset strobes: as %b ds %b required 0 0", bus_as, bus_ds); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset rsp: valid %b err %b required 0 0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset rsp_rdata: got %h required 00", rsp_rdata); end
    checks++; if (bus_addr !== 8'h00 || bus_wdata !== 8'h00 || bus_rw !== 1'b0) begin errors++; $display("FAIL reset bus: addr %h wdata %h rw %b required 00 00 0", bus_addr, bus_wdata, bus_rw); end
    checks++; if (irq_sync !== 1'b0) begin errors++; $display("FAIL reset irq_sync: got %b required 0", irq_sync); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset ready_before_clk: got %b required 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset ready_after_clk: got %b required 1", cmd_ready); end
  endtask

  task automatic test_write_ctr();
    int acc; bit ok; exp_t e; obs_t o;
    as_q.delete(); ds_q.delete();
    issue(1'b1, 8'h04, 8'hC0, acc);
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    issue(1'b0, 8'h04, 8'h00, acc);
    last_rd = 8'hC0;
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_ctr rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL write_ctr err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL write_ctr latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL write_ctr rdata: got %h required %h", o.rdata, e.rdata); end
    end
    checks++; if (core_mem[4] !== 8'hC0) begin errors++; $display("FAIL write_ctr core_ctr: got %h required c0", core_mem[4]); end
    checks++; if (as_q.size() < 1 || as_q[0] != AS_LEN) begin errors++; $display("FAIL write_ctr as_len: got %0d required %0d", (as_q.size() > 0) ? as_q[0] : -1, AS_LEN); end
    checks++; if (ds_q.size() < 1 || ds_q[0] != STROBE_CYC) begin errors++; $display("FAIL write_ctr ds_len: got %0d required %0d", (ds_q.size() > 0) ? ds_q[0] : -1, STROBE_CYC); end
  endtask

  task automatic test_prer_readback();
    int acc; bit ok; exp_t e; obs_t o;
    issue(1'b1, 8'h02, 8'h31, acc);
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    issue(1'b0, 8'h02, 8'h00, acc);
    last_rd = 8'h31;
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prer rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL prer err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL prer latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL prer rdata: got %h required %h", o.rdata, e.rdata); end
    end
  endtask

  task automatic test_illegal();
    int acc; bit ok; exp_t e; obs_t o; int as0, ds0;
    as0 = as_total; ds0 = ds_total;
    issue(1'b1, 8'h08, 8'h55, acc);
    exp_q.push_back(mk(1'b1, last_rd, acc, LAT_ERR));
    issue(1'b0, 8'h05, 8'h00, acc);
    exp_q.push_back(mk(1'b1, last_rd, acc, LAT_ERR));
    wait_rsp(ok);
    checks++; if (as_total != as0 || ds_total != ds0) begin errors++; $display("FAIL illegal bus_activity: as %0d ds %0d cycles required 0 0", as_total - as0, ds_total - ds0); end
    checks++; if (bus_addr !== 8'h02 || bus_rw !== 1'b0) begin errors++; $display("FAIL illegal bus_untouched: addr %h rw %b required 02 0", bus_addr, bus_rw); end
    issue(1'b0, 8'h00, 8'h00, acc);
    last_rd = 8'h3C;
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL illegal err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL illegal latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL illegal rdata: got %h required %h", o.rdata, e.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [3] = '{8'hA5, 8'h5A, 8'hFF};
    int acc [3]; int idx; bit ok; exp_t e; obs_t o;
    gap_q.delete();
    idx = 0;
    cmd_rw = 1'b1; cmd_addr = 8'h0E; cmd_wdata = data[0]; cmd_valid = 1'b1;
    for (int n = 0; n < 80 && idx < 3; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc[idx] = cyc;
        exp_q.push_back(mk(1'b0, last_rd, cyc, LAT_OK));
        idx++;
        @(posedge clk); #1;
        if (idx < 3) cmd_wdata = data[idx];
        else cmd_valid = 1'b0;
      end
    end
    if (idx < 3) begin @(posedge clk); #1; cmd_valid = 1'b0; end
    checks++; if (idx != 3) begin errors++; $display("FAIL b2b accepts: got %0d required 3", idx); end
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    if (idx == 3) begin
      checks++; if (acc[1] - acc[0] != PERIOD) begin errors++; $display("FAIL b2b period01: got %0d required %0d", acc[1] - acc[0], PERIOD); end
      checks++; if (acc[2] - acc[1] != PERIOD) begin errors++; $display("FAIL b2b period12: got %0d required %0d", acc[2] - acc[1], PERIOD); end
    end
    checks++; if (gap_q.size() < 3 || gap_q[1] < RECOV_CYC || gap_q[2] < RECOV_CYC) begin errors++; $display("FAIL b2b as_gap: %0d gaps seen, required 3 with >= %0d low cycles", gap_q.size(), RECOV_CYC); end
    checks++; if (core_mem[14] !== 8'hFF) begin errors++; $display("FAIL b2b core_dr: got %h required ff", core_mem[14]); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL b2b err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL b2b latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
    end
  endtask

  task automatic test_reset_mid();
    int acc; bit ok; bit seen; exp_t e; obs_t o;
    issue(1'b0, 8'h02, 8'h00, acc);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus_ds;
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_mid ds_timeout: ds never rose"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_as !== 1'b0 || bus_ds !== 1'b0) begin errors++; $display("FAIL reset_mid strobes: as %b ds %b required 0 0", bus_as, bus_ds); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_mid rsp_rdata: got %h required 00", rsp_rdata); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    last_rd = 8'h00;
    repeat (LAT_OK + 4) @(posedge clk);
    #1;
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL reset_mid aborted_rsp: got %0d responses required 0", rsp_q.size()); end
    rsp_q.delete();
    issue(1'b1, 8'h0A, 8'h77, acc);
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    issue(1'b0, 8'h0A, 8'h00, acc);
    last_rd = 8'h77;
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_mid rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL reset_mid err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL reset_mid latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL reset_mid rdata: got %h required %h", o.rdata, e.rdata); end
    end
  endtask

  task automatic test_irq();
    int acc; bit ok; int hits; int first; exp_t e; obs_t o;
    issue(1'b0, 8'h0A, 8'h00, acc);
    exp_q.push_back(mk(1'b0, last_rd, acc, LAT_OK));
    // irq is high for exactly the cycle stamped acc+1
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    hits = 0; first = -1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (irq_sync) begin
        hits++;
        if (first < 0) first = cyc;
      end
    end
    @(posedge clk); #1;
    checks++; if (hits != 1) begin errors++; $display("FAIL irq pulse_len: got %0d cycles required 1", hits); end
    checks++; if (first != acc + 3) begin errors++; $display("FAIL irq delay: got %0d required %0d", first - (acc + 1), 2); end
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL irq rsp_timeout: got %0d responses required %0d", rsp_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front(); o = rsp_q.pop_front();
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL irq err: got %b required %b", o.err, e.err); end
      checks++; if (o.cyc - e.acc !== e.lat) begin errors++; $display("FAIL irq latency: got %0d required %0d", o.cyc - e.acc, e.lat); end
      checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL irq rdata: got %h required %h", o.rdata, e.rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_write_ctr();
    test_prer_readback();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
